// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the wall-follower motor control slice.
//
// Contents
//   sched_state_t : state encoding of pid_loop_scheduler
//   pid_ch_t      : loop id presented to the shared PID core
//   sat_signed()  : symmetric signed clamp to [-limit, +limit]
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WALL_REQ   = 3'd1,
    WALL_WAIT  = 3'd2,
    LEFT_REQ   = 3'd3,
    LEFT_WAIT  = 3'd4,
    RIGHT_REQ  = 3'd5,
    RIGHT_WAIT = 3'd6,
    COMMIT     = 3'd7
  } sched_state_t;

  typedef enum logic [1:0] {
    CH_WALL  = 2'd0,
    CH_LEFT  = 2'd1,
    CH_RIGHT = 2'd2
  } pid_ch_t;

  // Clamp a 32-bit signed value symmetrically around zero. The limit is
  // expected to be non-negative.
  function automatic logic signed [31:0] sat_signed(
    input logic signed [31:0] value,
    input logic signed [31:0] limit
  );
    if (value > limit) begin
      return limit;
    end else if (value < -limit) begin
      return -limit;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/signed_saturate.sv
// Symmetric signed saturation between buses of different widths.
//
// Parameters
//   IN_W  : width of the signed input
//   OUT_W : width of the signed output (must hold +/-LIMIT)
//   LIMIT : clamp magnitude
// Ports
//   value_i : signed input value
//   value_o : input clamped to [-LIMIT, +LIMIT]
module signed_saturate
  import motor_ctrl_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 11,
  parameter int LIMIT = 50
) (
  input  logic signed [IN_W-1:0]  value_i,
  output logic signed [OUT_W-1:0] value_o
);

  logic signed [31:0] valueWide;
  logic signed [31:0] valueSat;

  // Sign-extend to the helper's working width before clamping; after the
  // clamp the value fits OUT_W so the final narrowing loses nothing.
  assign valueWide = {{(32-IN_W){value_i[IN_W-1]}}, value_i};
  assign valueSat  = sat_signed(valueWide, LIMIT);
  assign value_o   = OUT_W'(valueSat);

endmodule

// File: rtl/pid_loop_scheduler.sv
// Time-multiplexes one shared PID core over the three wall-follower loops
// (wall distance, left wheel speed, right wheel speed) and commits the three
// saturated results to motor_control together once per sample tick.
//
// Ports
//   clk, reset            : clock and asynchronous active-low reset
//   enable, sample_tick   : scheduler enable and update strobe
//   dist_*/rpm_*          : setpoints and measurements (unsigned)
//   pid_req_*             : request channel to the PID core (valid/ready)
//   pid_rsp_*             : result from the PID core
//   rpm_offset            : saturated wall-loop output
//   duty_cycle_offset_l/r : saturated wheel-loop outputs
//   cycle_done            : pulse in the cycle the new offsets appear
//   overrun               : sticky, a tick arrived while a cycle was running
//   pid_fault             : sticky response-timeout flag (PID_RSP_TIMEOUT_EN)
//
// Build option
//   PID_RSP_TIMEOUT_EN : adds a watchdog on each wait state and pid_fault.
module pid_loop_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int RPM_RESOLUTION = 10,
  parameter int PWM_RESOLUTION = 16,
  parameter int DIST_W         = 12,
  parameter int ERR_W          = 18,
  parameter int MAX_RPM_OFFSET = 50
`ifdef PID_RSP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             sample_tick,
  input  logic [DIST_W-1:0]                dist_setpoint,
  input  logic [DIST_W-1:0]                dist_meas,
  input  logic [RPM_RESOLUTION-1:0]        rpm_setpoint_l,
  input  logic [RPM_RESOLUTION-1:0]        rpm_setpoint_r,
  input  logic [RPM_RESOLUTION-1:0]        rpm_meas_l,
  input  logic [RPM_RESOLUTION-1:0]        rpm_meas_r,
  output logic                             pid_req_valid,
  input  logic                             pid_req_ready,
  output logic [1:0]                       pid_req_ch,
  output logic signed [ERR_W-1:0]          pid_req_error,
  input  logic                             pid_rsp_valid,
  input  logic signed [ERR_W-1:0]          pid_rsp_result,
  output logic signed [RPM_RESOLUTION:0]   rpm_offset,
  output logic signed [PWM_RESOLUTION:0]   duty_cycle_offset_l,
  output logic signed [PWM_RESOLUTION:0]   duty_cycle_offset_r,
  output logic                             cycle_done,
  output logic                             overrun
`ifdef PID_RSP_TIMEOUT_EN
  ,
  output logic                             pid_fault
`endif
);

  localparam int DUTY_LIMIT = (1 << PWM_RESOLUTION) - 1;

  sched_state_t state_q, state_d;

  logic signed [RPM_RESOLUTION:0] rpmOffset_q, rpmOffset_d;
  logic signed [RPM_RESOLUTION:0] wallSh_q, wallSh_d;
  logic signed [PWM_RESOLUTION:0] dutyL_q, dutyL_d;
  logic signed [PWM_RESOLUTION:0] dutyR_q, dutyR_d;
  logic signed [PWM_RESOLUTION:0] leftSh_q, leftSh_d;
  logic signed [PWM_RESOLUTION:0] rightSh_q, rightSh_d;
  logic                           cycleDone_q, cycleDone_d;
  logic                           overrun_q, overrun_d;

  logic signed [ERR_W-1:0]          wallErr, leftErr, rightErr;
  logic signed [RPM_RESOLUTION:0]   rpmSat;
  logic signed [PWM_RESOLUTION:0]   dutySat;
  logic                             timeoutHit;

  // Operands are zero-extended first so the difference of two unsigned
  // values always lands in a signed bus wide enough to hold it.
  assign wallErr  = $signed(ERR_W'(dist_setpoint))  - $signed(ERR_W'(dist_meas));
  assign leftErr  = $signed(ERR_W'(rpm_setpoint_l)) - $signed(ERR_W'(rpm_meas_l));
  assign rightErr = $signed(ERR_W'(rpm_setpoint_r)) - $signed(ERR_W'(rpm_meas_r));

  // One saturator per output range; both wheel loops share the duty one
  // because only one response is ever in flight.
  signed_saturate #(
    .IN_W (ERR_W),
    .OUT_W(RPM_RESOLUTION + 1),
    .LIMIT(MAX_RPM_OFFSET)
  ) uRpmSat (
    .value_i(pid_rsp_result),
    .value_o(rpmSat)
  );

  signed_saturate #(
    .IN_W (ERR_W),
    .OUT_W(PWM_RESOLUTION + 1),
    .LIMIT(DUTY_LIMIT)
  ) uDutySat (
    .value_i(pid_rsp_result),
    .value_o(dutySat)
  );

`ifdef PID_RSP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             inWait;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             pidFault_q, pidFault_d;

  // The counter restarts whenever the FSM is outside a wait state, so it
  // reads zero on the first cycle of every wait.
  assign inWait     = (state_q == WALL_WAIT) || (state_q == LEFT_WAIT) ||
                      (state_q == RIGHT_WAIT);
  assign timeoutHit = inWait && !pid_rsp_valid &&
                      (waitCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign waitCnt_d  = inWait ? (waitCnt_q + CNT_W'(1)) : '0;
  assign pidFault_d = pidFault_q | timeoutHit;
  assign pid_fault  = pidFault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt_q  <= '0;
      pidFault_q <= 1'b0;
    end else begin
      waitCnt_q  <= waitCnt_d;
      pidFault_q <= pidFault_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state and request decode. Requests are pure functions of the state
  // so ch/error stay stable for as long as a REQ state is held by ready.
  always_comb begin
    state_d       = state_q;
    rpmOffset_d   = rpmOffset_q;
    dutyL_d       = dutyL_q;
    dutyR_d       = dutyR_q;
    wallSh_d      = wallSh_q;
    leftSh_d      = leftSh_q;
    rightSh_d     = rightSh_q;
    cycleDone_d   = 1'b0;
    overrun_d     = overrun_q;
    pid_req_valid = 1'b0;
    pid_req_ch    = CH_WALL;
    pid_req_error = '0;

    // Ticks are never queued: any tick outside IDLE is lost and flagged.
    if (sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!enable) begin
          rpmOffset_d = '0;
          dutyL_d     = '0;
          dutyR_d     = '0;
          overrun_d   = 1'b0;
        end else if (sample_tick) begin
          state_d = WALL_REQ;
        end
      end
      WALL_REQ: begin
        pid_req_valid = 1'b1;
        pid_req_ch    = CH_WALL;
        pid_req_error = wallErr;
        if (pid_req_ready) state_d = WALL_WAIT;
      end
      WALL_WAIT: begin
        if (pid_rsp_valid) begin
          wallSh_d = rpmSat;
          state_d  = LEFT_REQ;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      LEFT_REQ: begin
        pid_req_valid = 1'b1;
        pid_req_ch    = CH_LEFT;
        pid_req_error = leftErr;
        if (pid_req_ready) state_d = LEFT_WAIT;
      end
      LEFT_WAIT: begin
        if (pid_rsp_valid) begin
          leftSh_d = dutySat;
          state_d  = RIGHT_REQ;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      RIGHT_REQ: begin
        pid_req_valid = 1'b1;
        pid_req_ch    = CH_RIGHT;
        pid_req_error = rightErr;
        if (pid_req_ready) state_d = RIGHT_WAIT;
      end
      RIGHT_WAIT: begin
        if (pid_rsp_valid) begin
          rightSh_d = dutySat;
          state_d   = COMMIT;
        end else if (timeoutHit) begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        rpmOffset_d = wallSh_q;
        dutyL_d     = leftSh_q;
        dutyR_d     = rightSh_q;
        cycleDone_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rpmOffset_q <= '0;
      dutyL_q     <= '0;
      dutyR_q     <= '0;
      wallSh_q    <= '0;
      leftSh_q    <= '0;
      rightSh_q   <= '0;
      cycleDone_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rpmOffset_q <= rpmOffset_d;
      dutyL_q     <= dutyL_d;
      dutyR_q     <= dutyR_d;
      wallSh_q    <= wallSh_d;
      leftSh_q    <= leftSh_d;
      rightSh_q   <= rightSh_d;
      cycleDone_q <= cycleDone_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rpm_offset          = rpmOffset_q;
  assign duty_cycle_offset_l = dutyL_q;
  assign duty_cycle_offset_r = dutyR_q;
  assign cycle_done          = cycleDone_q;
  assign overrun             = overrun_q;

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Scoreboard bench for pid_loop_scheduler. A behavioural PID core answers
// each accepted request one cycle later with error*gain[ch]; each stimulus
// pushes its hand-computed committed offsets, and a monitor pops and checks
// them whenever cycle_done is seen.
module tb_pid_loop_scheduler;

  localparam int ERR_W = 18;

  typedef struct {
    int rpm;
    int dutyL;
    int dutyR;
    int doneAt;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rstN;
  logic                     enable;
  logic                     sampleTick;
  logic [11:0]              distSp, distMeas;
  logic [9:0]               rpmSpL, rpmSpR, rpmMeasL, rpmMeasR;
  logic                     reqValid;
  logic                     reqReady;
  logic [1:0]               reqCh;
  logic signed [ERR_W-1:0]  reqError;
  logic                     rspValid;
  logic signed [ERR_W-1:0]  rspResult;
  logic signed [10:0]       rpmOffset;
  logic signed [16:0]       dutyL, dutyR;
  logic                     cycleDone;
  logic                     overrun;
`ifdef PID_RSP_TIMEOUT_EN
  logic                     pidFault;
`endif

  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  exp_t expQ[$];
  exp_t got;
  int   gain[3];
  int   stallLeft = 0;
  int   stallExpErr = 0;
  bit   dropRsp = 1'b0;
  bit   strayReq = 1'b0;
  logic                    hsSeen;
  logic [1:0]              hsCh;
  logic signed [ERR_W-1:0] hsErr;

  pid_loop_scheduler dut (
    .clk                (clk),
    .reset              (rstN),
    .enable             (enable),
    .sample_tick        (sampleTick),
    .dist_setpoint      (distSp),
    .dist_meas          (distMeas),
    .rpm_setpoint_l     (rpmSpL),
    .rpm_setpoint_r     (rpmSpR),
    .rpm_meas_l         (rpmMeasL),
    .rpm_meas_r         (rpmMeasR),
    .pid_req_valid      (reqValid),
    .pid_req_ready      (reqReady),
    .pid_req_ch         (reqCh),
    .pid_req_error      (reqError),
    .pid_rsp_valid      (rspValid),
    .pid_rsp_result     (rspResult),
    .rpm_offset         (rpmOffset),
    .duty_cycle_offset_l(dutyL),
    .duty_cycle_offset_r(dutyR),
    .cycle_done         (cycleDone),
`ifdef PID_RSP_TIMEOUT_EN
    .overrun            (overrun),
    .pid_fault          (pidFault)
`else
    .overrun            (overrun)
`endif
  );

  // 125 MHz clock and a free-running edge counter for latency checks.
  always #4 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // PID core model: captures a handshake mid-cycle, answers in the cycle
  // after the accepting edge.
  initial begin
    rspValid  = 1'b0;
    rspResult = '0;
    forever begin
      @(negedge clk);
      hsSeen = reqValid && reqReady;
      hsCh   = reqCh;
      hsErr  = reqError;
      @(posedge clk);
      #1;
      rspValid = 1'b0;
      if (strayReq) begin
        rspValid  = 1'b1;
        rspResult = 18'sd77;
        strayReq  = 1'b0;
      end else if (hsSeen && !dropRsp) begin
        rspValid  = 1'b1;
        rspResult = ERR_W'(int'(hsErr) * gain[hsCh]);
      end
    end
  end

  // Ready generator: holds ready low for stallLeft cycles of LEFT_REQ.
  initial begin
    reqReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stallLeft > 0 && reqValid && reqCh == 2'd1) begin
        stallLeft--;
        reqReady = 1'b0;
      end else begin
        reqReady = 1'b1;
      end
    end
  end

  // While the left request is stalled its error must not move.
  always @(negedge clk) begin
    if (rstN && reqValid && reqCh == 2'd1 && !reqReady) begin
      checkOutput("stall_err", int'(reqError), stallExpErr);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstN && cycleDone) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_cycle_done", 1, 0);
      end else begin
        got = expQ.pop_front();
        checkOutput("rpm_offset", int'(rpmOffset), got.rpm);
        checkOutput("duty_l", int'(dutyL), got.dutyL);
        checkOutput("duty_r", int'(dutyR), got.dutyR);
        if (got.doneAt >= 0) checkOutput("latency", cycleCnt, got.doneAt);
      end
    end
  end

  // Program inputs, optionally push the expected commit, and pulse a tick.
  task automatic applyStimulus(
    input int ds, input int dm, input int sl, input int ml, input int sr, input int mr,
    input int gw, input int gl, input int gr,
    input bit push, input int eRpm, input int eL, input int eR, input bit chkLat
  );
    exp_t e;
    @(negedge clk);
    distSp   = 12'(ds);
    distMeas = 12'(dm);
    rpmSpL   = 10'(sl);
    rpmMeasL = 10'(ml);
    rpmSpR   = 10'(sr);
    rpmMeasR = 10'(mr);
    gain[0]  = gw;
    gain[1]  = gl;
    gain[2]  = gr;
    if (push) begin
      e.rpm    = eRpm;
      e.dutyL  = eL;
      e.dutyR  = eR;
      e.doneAt = chkLat ? cycleCnt + 8 : -1;
      expQ.push_back(e);
    end
    sampleTick = 1'b1;
    @(negedge clk);
    sampleTick = 1'b0;
  endtask

  task automatic pulseTick();
    @(negedge clk);
    sampleTick = 1'b1;
    @(negedge clk);
    sampleTick = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; enable = 1'b0; sampleTick = 1'b0;
    distSp = '0; distMeas = '0; rpmSpL = '0; rpmMeasL = '0; rpmSpR = '0; rpmMeasR = '0;
    gain[0] = 1; gain[1] = 1; gain[2] = 1;
    repeat (3) @(negedge clk);

    checkOutput("reset_rpm", int'(rpmOffset), 0);
    checkOutput("reset_duty_l", int'(dutyL), 0);
    checkOutput("reset_duty_r", int'(dutyR), 0);
    checkOutput("reset_req_valid", int'(reqValid), 0);
    checkOutput("reset_cycle_done", int'(cycleDone), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    rstN = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    $display("[TB] nominal cycle");
    applyStimulus(200, 180, 150, 140, 150, 155, 1, 1, 1, 1, 20, 10, -5, 1);
    waitDrain();

    $display("[TB] saturation cycles");
    applyStimulus(100, 151, 150, 50, 0, 1000, 1, 1000, 100, 1, -50, 65535, -65535, 1);
    waitDrain();
    applyStimulus(500, 200, 0, 1000, 10, 60, 1, 100, 1, 1, 50, -65535, -50, 1);
    waitDrain();
    applyStimulus(150, 100, 0, 257, 257, 0, 1, 255, 255, 1, 50, -65535, 65535, 1);
    waitDrain();

    $display("[TB] backpressure on left request");
    stallExpErr = -30;
    stallLeft = 5;
    applyStimulus(300, 310, 100, 130, 400, 300, 1, 1, 1, 1, -10, -30, 100, 0);
    waitDrain();
    checkOutput("stall_cycles_consumed", stallLeft, 0);
    checkOutput("overrun_clear_before", int'(overrun), 0);

    $display("[TB] overrun");
    applyStimulus(250, 240, 200, 195, 100, 103, 1, 1, 1, 1, 10, 5, -3, 1);
    repeat (1) @(negedge clk);
    pulseTick();
    waitDrain();
    repeat (10) @(negedge clk);
    checkOutput("overrun_set", int'(overrun), 1);

    $display("[TB] enable low in idle");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("disable_rpm", int'(rpmOffset), 0);
    checkOutput("disable_duty_l", int'(dutyL), 0);
    checkOutput("disable_duty_r", int'(dutyR), 0);
    checkOutput("disable_overrun", int'(overrun), 0);
    enable = 1'b1;

    $display("[TB] stray response in idle");
    @(negedge clk);
    strayReq = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("stray_rpm", int'(rpmOffset), 0);
    checkOutput("stray_req_valid", int'(reqValid), 0);
    applyStimulus(200, 180, 150, 140, 150, 155, 1, 1, 1, 1, 20, 10, -5, 1);
    waitDrain();

    $display("[TB] reset in right wait");
    applyStimulus(300, 100, 300, 100, 300, 100, 1, 1, 1, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_rpm", int'(rpmOffset), 0);
    checkOutput("midreset_duty_l", int'(dutyL), 0);
    checkOutput("midreset_duty_r", int'(dutyR), 0);
    checkOutput("midreset_req_valid", int'(reqValid), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("post_reset_req_valid", int'(reqValid), 0);
    checkOutput("post_reset_rpm", int'(rpmOffset), 0);

    $display("[TB] enable falls mid-cycle");
    applyStimulus(180, 200, 50, 60, 60, 50, 1, 1, 1, 1, -20, -10, 10, 1);
    @(negedge clk);
    enable = 1'b0;
    waitDrain();
    pulseTick();
    repeat (12) @(negedge clk);
    checkOutput("disabled_rpm", int'(rpmOffset), 0);
    checkOutput("disabled_req_valid", int'(reqValid), 0);
    enable = 1'b1;

    applyStimulus(200, 180, 150, 140, 150, 155, 1, 1, 1, 1, 20, 10, -5, 1);
    waitDrain();

`ifdef PID_RSP_TIMEOUT_EN
    $display("[TB] response timeout");
    dropRsp = 1'b1;
    applyStimulus(400, 100, 100, 100, 100, 100, 1, 1, 1, 0, 0, 0, 0, 0);
    repeat (255) @(negedge clk);
    checkOutput("fault_before_limit", int'(pidFault), 0);
    @(negedge clk);
    checkOutput("fault_after_limit", int'(pidFault), 1);
    checkOutput("timeout_req_valid", int'(reqValid), 0);
    checkOutput("timeout_rpm", int'(rpmOffset), 20);
    checkOutput("timeout_duty_l", int'(dutyL), 10);
    checkOutput("timeout_duty_r", int'(dutyR), -5);
    dropRsp = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(250, 240, 200, 195, 100, 103, 1, 1, 1, 1, 10, 5, -3, 1);
    waitDrain();
    checkOutput("fault_sticky", int'(pidFault), 1);
`endif

    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
